sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO. Successor to the fixed 16x8 FIFO.

---
 rtl/sync_fifo_param.sv | 97 +++++++++
 tb/tb_sync_fifo_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level count, almost-full/almost-empty flags,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 4,
  parameter int unsigned FWFT      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        re,
  output logic [DATA_W-1:0]           data_out,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              wr_ok;
  logic              rd_ok;

  // Flags decode the registered count, so they reflect the state before this edge
  assign count        = count_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_TH));
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));

  assign wr_ok = we & ~full;
  assign rd_ok = re & ~empty;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count_q   <= count_d;
      overflow  <= we & full;
      underflow <= re & empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; forced to zero while nothing is stored
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out <= '0;
          rd_valid <= 1'b0;
        end else begin
          if (rd_ok) data_out <= mem[rd_ptr];
          rd_valid <= rd_ok;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read instance and an FWFT instance
// driven from hand-computed vectors.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       we, re;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       we1, re1;
  logic [7:0] din1;
  logic [7:0] dout1;
  logic       rd_valid1, full1, empty1, almost_full1, almost_empty1, overflow1, underflow1;
  logic [4:0] count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .we(we), .data_in(din), .re(re),
    .data_out(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .we(we1), .data_in(din1), .re(re1),
    .data_out(dout1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(almost_full1), .almost_empty(almost_empty1), .count(count1),
    .overflow(overflow1), .underflow(underflow1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; din = '0;
    we1 = 1'b0; re1 = 1'b0; din1 = '0;
    #1;
    tick(); tick();
    rst = 1'b0;

    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      we = 1'b1; din = 8'(i);
      tick();
      check("fill_count", 32'(count), 32'(i));
      check("fill_afull", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(full), 32'd1);
    din = 8'h77;
    tick();
    we = 1'b0;
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    tick();
    check("ovf_clear", 32'(overflow), 32'd0);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      re = 1'b1;
      tick();
      check("drain_dout", 32'(dout), 32'(i));
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_count", 32'(count), 32'(16 - i));
      check("drain_aempty", 32'(almost_empty), ((16 - i) <= 4) ? 32'd1 : 32'd0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    tick();
    re = 1'b0;
    check("unf_pulse", 32'(underflow), 32'd1);
    check("unf_valid", 32'(rd_valid), 32'd0);
    check("unf_hold", 32'(dout), 32'h10);
    tick();
    check("unf_clear", 32'(underflow), 32'd0);

    // Half fill, then steady-state simultaneous traffic across pointer wrap
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; din = 8'(8'h20 + i);
      tick();
    end
    check("half_count", 32'(count), 32'd8);
    for (int k = 0; k < 20; k++) begin
      we = 1'b1; re = 1'b1; din = 8'(8'h28 + k);
      tick();
      check("rw_dout", 32'(dout), 32'(8'h20 + k));
      check("rw_count", 32'(count), 32'd8);
    end
    re = 1'b0;
    // Remaining 0x34..0x3B; top up with 0x3C..0x43
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; din = 8'(8'h3C + i);
      tick();
    end
    check("refill_full", 32'(full), 32'd1);

    // Full with we&re: read accepted, write dropped
    we = 1'b1; re = 1'b1; din = 8'h99;
    tick();
    we = 1'b0; re = 1'b0;
    check("fullrw_dout", 32'(dout), 32'h34);
    check("fullrw_count", 32'(count), 32'd15);
    check("fullrw_ovf", 32'(overflow), 32'd1);

    for (int i = 0; i < 15; i++) begin
      re = 1'b1;
      tick();
      check("fullrw_drain", 32'(dout), 32'(8'h35 + i));
    end
    re = 1'b0;
    check("fullrw_empty", 32'(empty), 32'd1);

    // Empty with we&re: write accepted, read rejected
    we = 1'b1; re = 1'b1; din = 8'h5A;
    tick();
    we = 1'b0; re = 1'b0;
    check("emptyrw_count", 32'(count), 32'd1);
    check("emptyrw_unf", 32'(underflow), 32'd1);
    check("emptyrw_valid", 32'(rd_valid), 32'd0);
    re = 1'b1;
    tick();
    re = 1'b0;
    check("emptyrw_dout", 32'(dout), 32'h5A);
    check("emptyrw_drained", 32'(count), 32'd0);

    // First-word-fall-through instance
    check("fwft_idle_valid", 32'(rd_valid1), 32'd0);
    we1 = 1'b1; din1 = 8'hA5;
    tick();
    we1 = 1'b0;
    check("fwft_dout", 32'(dout1), 32'hA5);
    check("fwft_valid", 32'(rd_valid1), 32'd1);
    re1 = 1'b1;
    tick();
    re1 = 1'b0;
    check("fwft_pop_valid", 32'(rd_valid1), 32'd0);
    we1 = 1'b1; din1 = 8'hB1;
    tick();
    din1 = 8'hB2;
    tick();
    we1 = 1'b0;
    check("fwft_head1", 32'(dout1), 32'hB1);
    re1 = 1'b1;
    tick();
    re1 = 1'b0;
    check("fwft_head2", 32'(dout1), 32'hB2);
    check("fwft_count", 32'(count1), 32'd1);

    // Reset mid-operation overrides we&re
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; din = 8'(8'h60 + i);
      tick();
    end
    we = 1'b0;
    check("pre_rst_count", 32'(count), 32'd9);
    re = 1'b1;
    tick();
    check("pre_rst_dout", 32'(dout), 32'h60);
    rst = 1'b1; we = 1'b1; re = 1'b1; din = 8'hEE;
    tick();
    rst = 1'b0; we = 1'b0; re = 1'b0;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_dout", 32'(dout), 32'd0);
    check("mrst_valid", 32'(rd_valid), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    check("mrst_unf", 32'(underflow), 32'd0);
    check("mrst_fwft_count", 32'(count1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
